// File: rtl/imm_decode_ctrl_if.sv
// Fetch/execute handshake bundle for the decode-stage immediate controller.
// master drives fetch inputs, flush and ex_ready; slave is the controller side.
interface imm_decode_ctrl_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_inst;
    logic [XLEN-1:0] ex_pc;
    logic [2:0]      ex_imm_sel;
    logic            ex_illegal;

    modport master (
        output if_valid, if_inst, if_pc, flush, ex_ready,
        input  if_ready, ex_valid, ex_inst, ex_pc, ex_imm_sel, ex_illegal
    );

    modport slave (
        input  if_valid, if_inst, if_pc, flush, ex_ready,
        output if_ready, ex_valid, ex_inst, ex_pc, ex_imm_sel, ex_illegal
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: 2-entry instruction queue that tags each entry with
// its immediate format. Ports: clk, rst_n (async, active low), bus (slave).
// Optional macro IMM_ILLEGAL_TRAP_EN: illegal head reports and blocks the queue.
module imm_decode_ctrl #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              rst_n,
    imm_decode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_I    = 3'd1;
    localparam logic [2:0] SEL_S    = 3'd2;
    localparam logic [2:0] SEL_B    = 3'd3;
    localparam logic [2:0] SEL_U    = 3'd4;
    localparam logic [2:0] SEL_J    = 3'd5;

    state_t          state;
    state_t          state_nx;
    logic            wptr;
    logic            rptr;
    logic [XLEN-1:0] inst_q [2];
    logic [XLEN-1:0] pc_q   [2];
    logic [2:0]      sel_q  [2];
    logic            ill_q  [2];

    logic       accept;
    logic       pop;
    logic       blocked;
    logic [2:0] cls_sel;
    logic       cls_ill;

    // {illegal, imm_sel} from the opcode field
    function automatic logic [3:0] classify(input logic [6:0] op);
        logic [3:0] r;
        r = {1'b1, SEL_NONE};
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: r = {1'b0, SEL_I};
            7'b0100011:                         r = {1'b0, SEL_S};
            7'b1100011:                         r = {1'b0, SEL_B};
            7'b0110111, 7'b0010111:             r = {1'b0, SEL_U};
            7'b1101111:                         r = {1'b0, SEL_J};
            7'b0110011, 7'b0001111, 7'b1110011: r = {1'b0, SEL_NONE};
            default:                            r = {1'b1, SEL_NONE};
        endcase
        return r;
    endfunction

    assign {cls_ill, cls_sel} = classify(bus.if_inst[6:0]);

    assign bus.if_ready   = (state != FULL);
    assign bus.ex_valid   = (state != EMPTY);
    assign bus.ex_inst    = inst_q[rptr];
    assign bus.ex_pc      = pc_q[rptr];
    assign bus.ex_imm_sel = sel_q[rptr];

`ifdef IMM_ILLEGAL_TRAP_EN
    // An illegal head stays presented until flush or reset clears it
    assign blocked        = ill_q[rptr] & (state != EMPTY);
    assign bus.ex_illegal = ill_q[rptr];
`else
    logic unused_ill;
    assign unused_ill     = ill_q[0] ^ ill_q[1];
    assign blocked        = 1'b0;
    assign bus.ex_illegal = 1'b0;
`endif

    assign accept = bus.if_valid & bus.if_ready;
    assign pop    = bus.ex_valid & bus.ex_ready & ~blocked;

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (accept) state_nx = ONE;
            ONE: begin
                if (accept && !pop)      state_nx = FULL;
                else if (pop && !accept) state_nx = EMPTY;
            end
            FULL:  if (pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
        if (bus.flush) state_nx = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.flush) begin
                wptr <= 1'b0;
                rptr <= 1'b0;
            end else begin
                if (accept) wptr <= ~wptr;
                if (pop)    rptr <= ~rptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                sel_q[i]  <= '0;
                ill_q[i]  <= 1'b0;
            end
        end else if (accept && !bus.flush) begin
            inst_q[wptr] <= bus.if_inst;
            pc_q[wptr]   <= bus.if_pc;
            sel_q[wptr]  <= cls_sel;
            ill_q[wptr]  <= cls_ill;
        end
    end
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed plan steps then random
// traffic, checked against a queue-based reference model.
module tb_imm_decode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_decode_ctrl_if #(.XLEN(32)) bus ();

    imm_decode_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        ill;
    } ent_t;

    ent_t mq[$];

`ifdef IMM_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    function automatic ent_t mk(input logic [31:0] inst, input logic [31:0] pc);
        ent_t e;
        logic [6:0] op;
        op = inst[6:0];
        e.inst = inst;
        e.pc   = pc;
        e.ill  = 1'b0;
        e.sel  = 3'd0;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) e.sel = 3'd1;
        else if (op == 7'h23) e.sel = 3'd2;
        else if (op == 7'h63) e.sel = 3'd3;
        else if (op == 7'h37 || op == 7'h17) e.sel = 3'd4;
        else if (op == 7'h6f) e.sel = 3'd5;
        else if (op == 7'h33 || op == 7'h0f || op == 7'h73) e.sel = 3'd0;
        else e.ill = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("ex_valid", 32'(bus.ex_valid), 32'(mq.size() != 0));
        chk("if_ready", 32'(bus.if_ready), 32'(mq.size() < 2));
        if (!TRAP) chk("ex_illegal_tied", 32'(bus.ex_illegal), 32'd0);
        if (mq.size() != 0) begin
            chk("ex_inst", bus.ex_inst, mq[0].inst);
            chk("ex_pc", bus.ex_pc, mq[0].pc);
            chk("ex_imm_sel", 32'(bus.ex_imm_sel), 32'(mq[0].sel));
            if (TRAP) chk("ex_illegal", 32'(bus.ex_illegal), 32'(mq[0].ill));
        end
    endtask

    // Drive one cycle, update the model at the edge, check #1 after it
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
        bit acc;
        bit pp;
        bus.if_valid = v;
        bus.if_inst  = inst;
        bus.if_pc    = pc;
        bus.ex_ready = rdy;
        bus.flush    = fl;
        acc = v && (mq.size() < 2);
        pp  = (mq.size() > 0) && rdy && !(TRAP && mq[0].ill);
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(mk(inst, pc));
        end
        check_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.ex_valid), 32'd0);
        chk({tag, "_ready"}, 32'(bus.if_ready), 32'd1);
        chk({tag, "_inst"}, bus.ex_inst, 32'd0);
        chk({tag, "_pc"}, bus.ex_pc, 32'd0);
        chk({tag, "_sel"}, 32'(bus.ex_imm_sel), 32'd0);
        chk({tag, "_ill"}, 32'(bus.ex_illegal), 32'd0);
    endtask

    logic [6:0] ops [14] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6f, 7'h33, 7'h0f, 7'h73, 7'h7f, 7'h0b, 7'h00};

    initial begin
        logic [31:0] r;
        logic [31:0] inst;
        bus.if_valid = 1'b0;
        bus.if_inst  = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // addi streaming at full throughput
        cyc(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        chk("addi_sel", 32'(bus.ex_imm_sel), 32'd1);
        chk("addi_inst", bus.ex_inst, 32'h00500093);
        chk("addi_pc", bus.ex_pc, 32'h100);
        for (int i = 1; i < 4; i++)
            cyc(1'b1, 32'h00500093, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drained", 32'(bus.ex_valid), 32'd0);

        // back-pressure: sw then beq
        cyc(1'b1, 32'h00112023, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000463, 32'h204, 1'b0, 1'b0);
        chk("full_ready", 32'(bus.if_ready), 32'd0);
        chk("sw_sel", 32'(bus.ex_imm_sel), 32'd2);
        cyc(1'b1, 32'h00000013, 32'h208, 1'b0, 1'b0);
        chk("sw_hold", bus.ex_inst, 32'h00112023);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("beq_sel", 32'(bus.ex_imm_sel), 32'd3);
        chk("beq_ready", 32'(bus.if_ready), 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // flush while full, with accept and pop offered
        cyc(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000013, 32'h304, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000013, 32'h308, 1'b1, 1'b1);
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_ready", 32'(bus.if_ready), 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_after", 32'(bus.ex_valid), 32'd0);

        // lui then jal
        cyc(1'b1, 32'h12345037, 32'h400, 1'b0, 1'b0);
        cyc(1'b1, 32'h008000ef, 32'h404, 1'b0, 1'b0);
        chk("lui_sel", 32'(bus.ex_imm_sel), 32'd4);
        chk("lui_pc", bus.ex_pc, 32'h400);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("jal_sel", 32'(bus.ex_imm_sel), 32'd5);
        chk("jal_pc", bus.ex_pc, 32'h404);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // illegal opcode
        cyc(1'b1, 32'h0000007f, 32'h500, 1'b1, 1'b0);
        chk("ill_sel", 32'(bus.ex_imm_sel), 32'd0);
        chk("ill_flag", 32'(bus.ex_illegal), 32'(TRAP));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("ill_after", 32'(bus.ex_valid), 32'(TRAP));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // async reset with the queue at ONE
        cyc(1'b1, 32'h00112023, 32'h600, 1'b0, 1'b0);
        bus.if_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h00500093, 32'h700, 1'b0, 1'b0);
        chk("post_rst_accept", 32'(bus.ex_valid), 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            inst = $urandom;
            inst[6:0] = ops[r[3:0] % 14];
            cyc(r[4] | r[5], inst, $urandom, r[6] | r[7], (r[12:8] == 5'd0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Decode-stage controller that sits between instruction fetch and the immediate generator/execute stage. It buffers fetched instructions in a 2-entry queue with valid/ready handshakes on both sides. It classifies each instruction's immediate format from the opcode, tags the entry so the immediate generator and execute stage know how to consume it, and handles pipeline flush and back-pressure.

## Interface
Parameters:
- XLEN, 32, data width of instruction and PC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  controller can accept an instruction this cycle.
- if_inst  in  XLEN  instruction word.
- if_pc  in  XLEN  PC of the instruction.
- flush  in  1  discard all queued entries (branch redirect).
- ex_valid  out  1  head entry valid toward execute.
- ex_ready  in  1  execute consumes the head entry this cycle.
- ex_inst  out  XLEN  head instruction, feeds the immediate generator.
- ex_pc  out  XLEN  head PC.
- ex_imm_sel  out  3  immediate format of head: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- ex_illegal  out  1  head opcode unrecognised (see Configuration).

## Operation
- Queue is 2 entries, storage indexed by 1-bit read and write pointers, plus a count in the range 0..2.
- FSM states: EMPTY (count 0), ONE (count 1), FULL (count 2).
- Accept = if_valid & if_ready. Pop = ex_valid & ex_ready.
- Transitions:
  - EMPTY to ONE on accept.
  - ONE to FULL on accept without pop.
  - ONE to EMPTY on pop without accept.
  - ONE stays ONE on simultaneous accept and pop.
  - FULL to ONE on pop.
- if_ready = (state != FULL). It depends only on state, so there is no combinational path from ex_ready.
- ex_valid = (state != EMPTY). ex_* are driven directly from the head entry.
- Classification happens at enqueue and is stored with the entry:
  - 0010011, 0000011, 1100111 give I.
  - 0100011 gives S.
  - 1100011 gives B.
  - 0110111, 0010111 give U.
  - 1101111 gives J.
  - 0110011, 0001111, 1110011 give none.
  - Any other opcode gives none with the illegal flag set.
- Flush has priority over accept and pop in the same cycle. On the next edge, state goes to EMPTY and pointers go to 0; the accepted and popped entries are dropped. if_ready is not gated by flush.
- Entries hold their values while stalled. The head is stable while ex_valid & !ex_ready.
- Pointer wrap: each pointer is 1 bit and toggles modulo 2.

## Timing
- Reset values: state EMPTY, pointers 0, ex_valid 0, if_ready 1, ex_inst 0, ex_pc 0, ex_imm_sel 0, ex_illegal 0.
- Storage entries also reset to 0, so ex_* read 0 while empty.
- Latency: an instruction accepted at edge N is presented on ex_* from cycle N+1 (1-cycle latency).
- Full throughput in state ONE: one accept and one pop per cycle.
- Reset asserted mid-operation clears everything asynchronously. The first accept is possible in the first cycle after rst_n deasserts.

## Configuration
- IMM_ILLEGAL_TRAP_EN defined:
  - ex_illegal reports the stored illegal flag.
  - An illegal head entry blocks the queue: ex_valid is held 1 and the entry is not popped even if ex_ready is 1.
  - Only flush or reset clears it.
- IMM_ILLEGAL_TRAP_EN undefined:
  - ex_illegal is tied to 0.
  - Illegal opcodes flow through as imm_sel 0 and are popped normally.

## Test plan
- Reset, then hold if_valid=1 and ex_ready=1 with inst 0x00500093 (addi) and pc 0x100. Expect ex_valid=1 next cycle with ex_inst 0x00500093, ex_pc 0x100, ex_imm_sel 1, and then one instruction per cycle.
- ex_ready=0 while enqueuing 0x00112023 (sw) then 0x00000463 (beq). Expect if_ready=0 after the second accept, and the head stays at sw with imm_sel 2. Raise ex_ready: beq appears next with imm_sel 3, and if_ready=1.
- Queue FULL, assert flush together with if_valid=1 and ex_ready=1. Expect ex_valid=0 and if_ready=1 the next cycle, and nothing dequeued afterwards.
- Enqueue 0x12345037 (lui) then 0x008000ef (jal). Expect imm_sel 4 then 5, with the correct pcs preserved.
- With IMM_ILLEGAL_TRAP_EN defined, enqueue 0x0000007f and hold ex_ready=1. Expect ex_illegal=1 and ex_valid held 1 until flush. With the macro undefined, the entry pops with imm_sel 0 and ex_illegal 0.
- Assert rst_n=0 mid-stream with the queue at ONE. Expect immediate ex_valid=0 and if_ready=1, with all ex_* at 0.
